// File: rtl/fetch_sequencer.sv
// Dual-issue PC sequencer with fetch queue; entries visible to decode 1 cycle after fetch.
// Fetch stops when the queue is full unless decode dequeues in the same cycle; redirect flushes.
module fetch_sequencer #(
  parameter int                    PC_WIDTH = 16,
  parameter int                    FQ_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         imem_en,
  input  logic [31:0]                  instr1_in,
  input  logic [31:0]                  instr2_in,
  input  logic                         pred_hit,
  input  logic                         pred_taken,
  input  logic [PC_WIDTH-1:0]          pred_target,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_target,
  input  logic                         hlt,
  input  logic                         dec_ready,
  output logic                         dec_valid,
  output logic [31:0]                  dec_instr1,
  output logic [31:0]                  dec_instr2,
  output logic [PC_WIDTH-1:0]          dec_pc,
  output logic                         dec_pred_taken,
  output logic [$clog2(FQ_DEPTH):0]    fq_count,
  output logic                         halted
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FQ_FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0]         instr1;
    logic [31:0]         instr2;
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
  } fq_entry_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PTR_W-1:0]    head_ptr, head_nxt, tail_ptr, tail_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  fq_entry_t           fq_mem [FQ_DEPTH];
  fq_entry_t           head_ent;
  logic                deq, can_enq, enq, taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Storage needs no reset: outputs are masked by dec_valid while empty.
  always_ff @(posedge clk) begin
    if (enq) fq_mem[tail_ptr] <= '{instr1: instr1_in, instr2: instr2_in, pc: pc, pred_taken: taken};
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    head_nxt  = head_ptr;
    tail_nxt  = tail_ptr;
    cnt_nxt   = cnt;
    taken     = pred_hit & pred_taken;
    deq       = dec_valid & dec_ready;
    can_enq   = (state == RUN) && ((cnt < FQ_FULL) || deq);
    imem_en   = can_enq & ~redirect_valid;
    enq       = imem_en & ~hlt;

    if (redirect_valid) begin
      // Flush also cancels a halt that was fetched down the wrong path.
      state_nxt = RUN;
      pc_nxt    = redirect_target;
      head_nxt  = '0;
      tail_nxt  = '0;
      cnt_nxt   = '0;
    end else begin
      if (hlt) state_nxt = HALT;
      if (enq) begin
        pc_nxt   = taken ? pred_target : pc + PC_WIDTH'(2);
        tail_nxt = tail_ptr + PTR_W'(1);
      end
      if (deq) head_nxt = head_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   cnt_nxt = cnt + CNT_W'(1);
        2'b01:   cnt_nxt = cnt - CNT_W'(1);
        default: cnt_nxt = cnt;
      endcase
    end
  end

  assign head_ent       = fq_mem[head_ptr];
  assign dec_valid      = (cnt != '0);
  assign dec_instr1     = dec_valid ? head_ent.instr1 : '0;
  assign dec_instr2     = dec_valid ? head_ent.instr2 : '0;
  assign dec_pc         = dec_valid ? head_ent.pc : '0;
  assign dec_pred_taken = dec_valid & head_ent.pred_taken;
  assign fq_count       = cnt;
  assign halted         = (state == HALT);

endmodule
